// File: rtl/run_ctl.sv
// rtl/run_ctl.sv - Start/Done run-control sequencer: program launch, PC load, halt/watchdog completion
module run_ctl #(
  parameter int L        = 10,
  parameter int NPROG    = 3,
  parameter int PROG1_PC = 0,
  parameter int PROG2_PC = 190,
  parameter int PROG3_PC = 200,
  parameter int CW       = 16,
  parameter int MAXCYC   = 60000
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  input  logic [L-1:0]  ProgCtr,
  output logic          Run,
  output logic          LoadPC,
  output logic [L-1:0]  PCInit,
  output logic          Done,
  output logic          Timeout,
  output logic [1:0]    ProgIdx,
  output logic [CW-1:0] CycleCount,
  output logic [L-1:0]  HaltPC
);

  localparam logic [CW-1:0] LAST_CYC = CW'(MAXCYC - 1);
  localparam logic [1:0]    NPROG_W  = 2'(NPROG);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

  state_t        state, state_n;
  logic          start_r;
  logic          run_n, load_n, done_n, timeout_n;
  logic [L-1:0]  pcinit_n, haltpc_n;
  logic [1:0]    idx_n;
  logic [CW-1:0] cyc_n;

  wire rise = !start_r && Start;
  wire fall = start_r && !Start;

  function automatic logic [L-1:0] entry_pc(input logic [1:0] idx);
    case (idx)
      2'd1:    entry_pc = L'(PROG1_PC);
      2'd2:    entry_pc = L'(PROG2_PC);
      default: entry_pc = L'(PROG3_PC);
    endcase
  endfunction

  // Every output is computed here as a next value and registered below.
  always_comb begin
    state_n   = state;
    run_n     = Run;
    load_n    = 1'b0;
    pcinit_n  = PCInit;
    done_n    = Done;
    timeout_n = Timeout;
    idx_n     = ProgIdx;
    cyc_n     = CycleCount;
    haltpc_n  = HaltPC;
    case (state)
      S_IDLE, S_DONE: begin
        if (rise && (ProgIdx < NPROG_W)) begin
          state_n   = S_ARMED;
          idx_n     = ProgIdx + 2'd1;
          done_n    = 1'b0;
          timeout_n = 1'b0;
        end
      end
      S_ARMED: begin
        if (fall) begin
          state_n  = S_RUN;
          load_n   = 1'b1;
          run_n    = 1'b1;
          pcinit_n = entry_pc(ProgIdx);
          cyc_n    = '0;
        end
      end
      S_RUN: begin
        // Halt outranks the watchdog when both land in the same cycle.
        if (Halt) begin
          state_n  = S_DONE;
          haltpc_n = ProgCtr;
          run_n    = 1'b0;
          done_n   = 1'b1;
        end else if (CycleCount == LAST_CYC) begin
          state_n   = S_DONE;
          run_n     = 1'b0;
          done_n    = 1'b1;
          timeout_n = 1'b1;
        end else begin
          cyc_n = CycleCount + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      start_r    <= 1'b0;
      Run        <= 1'b0;
      LoadPC     <= 1'b0;
      PCInit     <= '0;
      Done       <= 1'b0;
      Timeout    <= 1'b0;
      ProgIdx    <= 2'd0;
      CycleCount <= '0;
      HaltPC     <= '0;
    end else begin
      state      <= state_n;
      start_r    <= Start;
      Run        <= run_n;
      LoadPC     <= load_n;
      PCInit     <= pcinit_n;
      Done       <= done_n;
      Timeout    <= timeout_n;
      ProgIdx    <= idx_n;
      CycleCount <= cyc_n;
      HaltPC     <= haltpc_n;
    end
  end

endmodule
